piso_stream: RTL and testbench
==============================

// Module: piso_stream
// PURPOSE
//  Parametrised parallel-in/serial-out streamer: next generation of the PISO latch/shift block.
//  Takes words over a valid/ready handshake into a one-word holding buffer.
//  Serialises each word MSB- or LSB-first at a programmable bit period (DIV clk cycles per bit).
//  Back-to-back words are sent with no idle gap when the buffer is refilled in time.
// PARAMETERS
//  WIDTH      8  word width in bits (>=2)
//  MSB_FIRST  1  1: din[WIDTH-1] sent first; 0: din[0] sent first
//  DIV        1  clk cycles per serial bit (>=1)
//  IDLE_LEVEL 0  dout level while no word is shifting
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      asynchronous active-low reset
//  din        in   WIDTH  parallel word
//  din_valid  in   1      din holds a word to send
//  din_ready  out  1      holding buffer empty; word accepted on edge with valid&ready
//  abort      in   1      synchronous flush of holding buffer and shifter
//  dout       out  1      serial data
//  busy       out  1      shifting or holding buffer occupied
//  done       out  1      one-cycle pulse after last bit of a word completes
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, hold empty, dout=IDLE_LEVEL, din_ready=1, busy=0, done=0,
//   all counters 0. Takes effect immediately, including mid-word; the partial word is discarded.
//  din_ready = !hold_valid (combinational from registered flag). Accept: din_valid&din_ready at edge
//   -> hold<=din, hold_valid<=1. din is ignored when din_ready=0.
//  States: IDLE, SHIFT.
//   IDLE: dout=IDLE_LEVEL. If hold_valid at edge: shreg<=hold, hold_valid<=0, bit_cnt<=0,
//    div_cnt<=0, ->SHIFT. Latency: word accepted at edge N, first bit on dout after edge N+1.
//   SHIFT: dout=shreg[WIDTH-1] (MSB_FIRST=1) or shreg[0] (MSB_FIRST=0); each bit held exactly DIV cycles.
//    div_cnt counts 0..DIV-1; at div_cnt==DIV-1 shift by one toward the output end (vacated bit 0),
//    bit_cnt++, div_cnt<=0.
//    Last bit (bit_cnt==WIDTH-1 and div_cnt==DIV-1) at edge: done<=1 for one cycle;
//     if hold_valid: reload shreg from hold, clear hold, stay SHIFT (gapless);
//     else ->IDLE.
//  Simultaneous: accept into hold on the same edge the hold->shreg transfer happens cannot occur
//   (ready=0 while hold_valid). Accept on the same edge IDLE sees hold empty: word goes to hold,
//   is loaded on the following edge.
//  abort=1 at edge: hold_valid<=0, ->IDLE, counters 0, done<=0; dout=IDLE_LEVEL next cycle.
//   abort has priority over accept and over load/reload on that edge.
//  busy = (state==SHIFT) | hold_valid.
//  Counters: div_cnt width clog2(DIV) (min 1), bit_cnt width clog2(WIDTH); no wrap beyond limits.
// TESTING (WIDTH=8, IDLE_LEVEL=0 unless stated)
//  1. Reset check: rst=0 mid-word (DIV=1, after 3 bits of 0xFF)
//     -> dout=0, busy=0, din_ready=1 immediately; no done pulse.
//  2. MSB_FIRST=1, DIV=1, send 0x55 -> dout 0,1,0,1,0,1,0,1 on 8 consecutive cycles;
//     done high one cycle after bit 8; then idle at 0.
//  3. MSB_FIRST=0, DIV=1, send 0xAA -> dout 0,1,0,1,0,1,0,1; busy high for exactly 8+1 cycles
//     from accept.
//  4. Back-to-back 0x0F then 0xCD (second accepted during first word) -> 16 contiguous bits
//     00001111 11001101, no idle cycle between, two done pulses 8 cycles apart,
//     din_ready low from second accept until reload.
//  5. DIV=3, send 0x80 -> dout=1 for 3 cycles then 0 for 21 cycles; done once.
//  6. abort after bit 4 of 0xF0 with 0x33 in hold -> dout=0 next cycle, busy=0, din_ready=1,
//     no done, 0x33 never sent.

Source files
------------

// File: rtl/piso_stream.sv
// Parallel-in/serial-out streamer: valid/ready word intake into a one-word holding buffer,
// serialised MSB- or LSB-first at DIV clocks per bit, gapless when the buffer is refilled in time.
module piso_stream #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned MSB_FIRST  = 1,
   parameter int unsigned DIV        = 1,
   parameter logic        IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             abort,
   output logic             dout,
   output logic             busy,
   output logic             done
);

   localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned BitW = $clog2(WIDTH);
   localparam logic [DivW-1:0] DivMax = DivW'(DIV - 1);
   localparam logic [BitW-1:0] BitMax = BitW'(WIDTH - 1);

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   state_e            r_state;
   logic [WIDTH-1:0]  r_hold;
   logic              r_hold_valid;
   logic [WIDTH-1:0]  r_shreg;
   logic [DivW-1:0]   r_div_cnt;
   logic [BitW-1:0]   r_bit_cnt;
   logic              r_done;

   logic [WIDTH-1:0]  w_shift_next;
   logic              w_out_bit;

   // Shift toward the output end; the vacated bit is always 0.
   assign w_shift_next = (MSB_FIRST != 0) ? {r_shreg[WIDTH-2:0], 1'b0}
                                          : {1'b0, r_shreg[WIDTH-1:1]};
   assign w_out_bit    = (MSB_FIRST != 0) ? r_shreg[WIDTH-1] : r_shreg[0];

   assign din_ready = ~r_hold_valid;
   assign busy      = (r_state == StShift) | r_hold_valid;
   assign dout      = (r_state == StShift) ? w_out_bit : IDLE_LEVEL;
   assign done      = r_done;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= StIdle;
         r_hold       <= '0;
         r_hold_valid <= 1'b0;
         r_shreg      <= '0;
         r_div_cnt    <= '0;
         r_bit_cnt    <= '0;
         r_done       <= 1'b0;
      end else if (abort) begin
         r_state      <= StIdle;
         r_hold_valid <= 1'b0;
         r_div_cnt    <= '0;
         r_bit_cnt    <= '0;
         r_done       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         // Accept and hold->shreg transfer are mutually exclusive via r_hold_valid.
         if (din_valid && !r_hold_valid) begin
            r_hold       <= din;
            r_hold_valid <= 1'b1;
         end
         unique case (r_state)
            StIdle: begin
               if (r_hold_valid) begin
                  r_shreg      <= r_hold;
                  r_hold_valid <= 1'b0;
                  r_div_cnt    <= '0;
                  r_bit_cnt    <= '0;
                  r_state      <= StShift;
               end
            end
            StShift: begin
               if (r_div_cnt == DivMax) begin
                  r_div_cnt <= '0;
                  if (r_bit_cnt == BitMax) begin
                     r_done    <= 1'b1;
                     r_bit_cnt <= '0;
                     if (r_hold_valid) begin
                        r_shreg      <= r_hold;
                        r_hold_valid <= 1'b0;
                     end else begin
                        r_state <= StIdle;
                     end
                  end else begin
                     r_shreg   <= w_shift_next;
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end else begin
                  r_div_cnt <= r_div_cnt + 1'b1;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_piso_stream.sv
// Directed bench for piso_stream: three instances (MSB/DIV1, LSB/DIV1, MSB/DIV3) sharing clock,
// reset, data and abort; expected bit streams are written out by hand below.
module tb_piso_stream;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] din = 8'h00;
   logic       abort = 1'b0;
   logic       v_m = 1'b0, v_l = 1'b0, v_d = 1'b0;
   logic       rdy_m, dout_m, busy_m, done_m;
   logic       rdy_l, dout_l, busy_l, done_l;
   logic       rdy_d, dout_d, busy_d, done_d;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   piso_stream #(.WIDTH(8), .MSB_FIRST(1), .DIV(1), .IDLE_LEVEL(1'b0)) u_m (
      .clk(clk), .rst(rst), .din(din), .din_valid(v_m), .din_ready(rdy_m),
      .abort(abort), .dout(dout_m), .busy(busy_m), .done(done_m)
   );

   piso_stream #(.WIDTH(8), .MSB_FIRST(0), .DIV(1), .IDLE_LEVEL(1'b0)) u_l (
      .clk(clk), .rst(rst), .din(din), .din_valid(v_l), .din_ready(rdy_l),
      .abort(abort), .dout(dout_l), .busy(busy_l), .done(done_l)
   );

   piso_stream #(.WIDTH(8), .MSB_FIRST(1), .DIV(3), .IDLE_LEVEL(1'b0)) u_d (
      .clk(clk), .rst(rst), .din(din), .din_valid(v_d), .din_ready(rdy_d),
      .abort(abort), .dout(dout_d), .busy(busy_d), .done(done_d)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [7:0]  pat;
      logic [15:0] stream;
      int          busy_cnt;
      int          done_cnt;

      // 1. Reset state, then reset mid-word.
      #2;
      chk("rst_dout", dout_m, 1'b0);
      chk("rst_busy", busy_m, 1'b0);
      chk("rst_ready", rdy_m, 1'b1);
      chk("rst_done", done_m, 1'b0);
      step();
      rst = 1'b1;
      step();
      din = 8'hFF; v_m = 1'b1;
      step();
      v_m = 1'b0;
      chk("t1_busy_acc", busy_m, 1'b1);
      chk("t1_ready_acc", rdy_m, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t1_bit", dout_m, 1'b1);
      end
      rst = 1'b0;
      #1;
      chk("t1_rst_dout", dout_m, 1'b0);
      chk("t1_rst_busy", busy_m, 1'b0);
      chk("t1_rst_ready", rdy_m, 1'b1);
      chk("t1_rst_done", done_m, 1'b0);
      step();
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("t1_no_done", done_m, 1'b0);
         chk("t1_idle_dout", dout_m, 1'b0);
      end

      // 2. MSB-first 0x55.
      pat = 8'h55;
      din = pat; v_m = 1'b1;
      step();
      v_m = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("t2_bit", dout_m, pat[7-i]);
         chk("t2_done_low", done_m, 1'b0);
      end
      step();
      chk("t2_done", done_m, 1'b1);
      chk("t2_idle", dout_m, 1'b0);
      chk("t2_busy", busy_m, 1'b0);
      step();
      chk("t2_done_end", done_m, 1'b0);
      chk("t2_idle2", dout_m, 1'b0);

      // 3. LSB-first 0xAA; busy for 9 cycles from accept.
      pat = 8'hAA;
      din = pat; v_l = 1'b1;
      step();
      v_l = 1'b0;
      busy_cnt = 0;
      for (int k = 0; k < 12; k++) begin
         if (k >= 1 && k <= 8) chk("t3_bit", dout_l, pat[k-1]);
         chk("t3_done", done_l, (k == 9) ? 1'b1 : 1'b0);
         if (busy_l) busy_cnt++;
         step();
      end
      chk("t3_busy_cycles", busy_cnt, 9);

      // 4. Back-to-back 0x0F then 0xCD.
      stream = 16'h0FCD;
      din = 8'h0F; v_m = 1'b1;
      step();
      v_m = 1'b0;
      for (int i = 0; i < 18; i++) begin
         step();
         if (i == 0) begin
            din = 8'hCD; v_m = 1'b1;
         end
         if (i == 1) v_m = 1'b0;
         if (i < 16) chk("t4_bit", dout_m, stream[15-i]);
         chk("t4_done", done_m, (i == 8 || i == 16) ? 1'b1 : 1'b0);
         chk("t4_ready", rdy_m, (i >= 1 && i <= 7) ? 1'b0 : 1'b1);
         chk("t4_busy", busy_m, (i < 16) ? 1'b1 : 1'b0);
      end

      // 5. DIV=3, 0x80.
      din = 8'h80; v_d = 1'b1;
      step();
      v_d = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 27; i++) begin
         step();
         if (i < 24) chk("t5_bit", dout_d, (i < 3) ? 1'b1 : 1'b0);
         chk("t5_done", done_d, (i == 24) ? 1'b1 : 1'b0);
         if (done_d) done_cnt++;
      end
      chk("t5_done_count", done_cnt, 1);
      chk("t5_idle_dout", dout_d, 1'b0);

      // 6. Abort after bit 4 of 0xF0 with 0x33 waiting in hold.
      din = 8'hF0; v_m = 1'b1;
      step();
      v_m = 1'b0;
      step();
      din = 8'h33; v_m = 1'b1;
      step();
      v_m = 1'b0;
      chk("t6_hold_full", rdy_m, 1'b0);
      step();
      step();
      chk("t6_bit4", dout_m, 1'b1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("t6_dout", dout_m, 1'b0);
      chk("t6_busy", busy_m, 1'b0);
      chk("t6_ready", rdy_m, 1'b1);
      chk("t6_done", done_m, 1'b0);
      for (int i = 0; i < 12; i++) begin
         step();
         chk("t6_quiet_dout", dout_m, 1'b0);
         chk("t6_quiet_done", done_m, 1'b0);
         chk("t6_quiet_busy", busy_m, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
